// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel RAM write path.
package pixel_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pw_state_t;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  localparam logic [LANES-1:0] BYTEEN_FULL = 4'b1111;

  // Byte enables for a word whose last filled lane is `lane`.
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] lane);
    logic [LANES-1:0] mask;
    case (lane)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      2'd2:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pixel_writer_if.sv
// Pixel stream input plus RAM port A write bus of the pixel writer.
// slave: the pixel_writer side; master: the stream source / RAM model side.
interface pixel_writer_if #(
  parameter int ADDR_W = 17
);
  import pixel_pkg::*;

  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_sof;
  logic              pix_eof;
  logic              pix_ready;

  logic [ADDR_W-1:0] address_a;
  logic [WORD_W-1:0] data_a;
  logic [LANES-1:0]  byteena_a;
  logic              wren_a;

  modport slave (
    input  pix_data, pix_valid, pix_sof, pix_eof,
    output pix_ready, address_a, data_a, byteena_a, wren_a
  );

  modport master (
    output pix_data, pix_valid, pix_sof, pix_eof,
    input  pix_ready, address_a, data_a, byteena_a, wren_a
  );

endinterface

// File: rtl/pixel_packer.sv
// Packs 8-bit pixels little-endian into 32-bit words. A completed word
// (lane 3 filled, or the last pixel of a frame) is presented combinationally
// in the same cycle as the completing pixel.
module pixel_packer
  import pixel_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              take,       // pixel belongs to the current frame
  input  logic              first,      // restart packing at lane 0
  input  logic              last,       // final pixel of the frame
  input  logic [PIX_W-1:0]  pix,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic [LANES-1:0]  mask,
  output logic              word_last
);

  logic [1:0]        lane_q, lane_d, cur_lane;
  logic [WORD_W-1:0] acc_q, acc_d;

  // Merge the incoming pixel into the partial word and decide completion.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_lane   = first ? 2'd0 : lane_q;
    word       = first ? '0 : acc_q;
    word[PIX_W*cur_lane +: PIX_W] = pix;
    word_valid = take && ((cur_lane == 2'd3) || last);
    word_last  = take && last;
    mask       = last ? lane_mask(cur_lane) : BYTEEN_FULL;
    lane_d     = lane_q;
    acc_d      = acc_q;
    if (take) begin
      if (word_valid) begin
        lane_d = 2'd0;
        acc_d  = '0;              // keeps unfilled lanes of the next word at zero
      end else begin
        lane_d = cur_lane + 2'd1;
        acc_d  = word;
      end
    end
  end

  // Lane counter and assembly register.
  // NOTE: the assembly register is reset too, because a short final word
  // relies on its unfilled lanes reading as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= 2'd0;
      acc_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Pixel RAM port A writer: frame FSM, word pointer with wrap/overrun,
// one-cycle registered write stage. Optional frame counter enabled by
// defining PIXEL_WRITER_STATS_EN.
module pixel_writer
  import pixel_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 16384
) (
  input  logic         clk,
  input  logic         reset,
  pixel_writer_if.slave bus,
  output logic         frame_done,
  output logic         overrun
`ifdef PIXEL_WRITER_STATS_EN
  ,
  output logic [15:0]  frame_count
`endif
);

  if (FRAME_WORDS < 1) begin : g_bad_frame_words
    $error("pixel_writer: FRAME_WORDS must be at least 1");
  end
  if (longint'(BASE_ADDR) + longint'(FRAME_WORDS) - 1 > (longint'(1) << ADDR_W) - 1)
  begin : g_bad_addr_range
    $error("pixel_writer: frame does not fit in the ADDR_W address space");
  end

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_WORDS - 1);

  pw_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_cur;
  logic              wrapped_q, wrapped_d, wrapped_cur;
  logic              overrun_q, overrun_d;
  logic              wren_q, wren_d, frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [LANES-1:0]  byteena_q, byteena_d;
  logic              pix_ready, accept, take;
  logic              pk_valid, pk_last;
  logic [WORD_W-1:0] pk_word;
  logic [LANES-1:0]  pk_mask;

  // The write stage absorbs every word, so the only stall is reset itself.
  assign pix_ready = ~reset;
  assign accept    = bus.pix_valid && pix_ready;
  assign take      = accept && ((state_q == ACTIVE) || bus.pix_sof);

  pixel_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .take       (take),
    .first      (bus.pix_sof),
    .last       (bus.pix_eof),
    .pix        (bus.pix_data),
    .word_valid (pk_valid),
    .word       (pk_word),
    .mask       (pk_mask),
    .word_last  (pk_last)
  );

  // Frame FSM next state: sof (re)starts a frame, eof ends it.
  always_comb begin
    state_d = state_q;
    if (take) begin
      state_d = bus.pix_eof ? IDLE : ACTIVE;
    end
  end

  // Pointer, wrap tracking, overrun flag and write-stage next values.
  always_comb begin
    ptr_cur      = bus.pix_sof ? '0 : ptr_q;
    wrapped_cur  = bus.pix_sof ? 1'b0 : wrapped_q;
    ptr_d        = ptr_q;
    wrapped_d    = wrapped_q;
    overrun_d    = overrun_q;
    wren_d       = 1'b0;
    byteena_d    = '0;
    frame_done_d = 1'b0;
    address_d    = address_q;
    data_d       = data_q;
    if (take) begin
      ptr_d     = ptr_cur;
      wrapped_d = wrapped_cur;
      if (bus.pix_sof) overrun_d = 1'b0;
    end
    if (pk_valid) begin
      wren_d       = 1'b1;
      byteena_d    = pk_mask;
      frame_done_d = pk_last;
      address_d    = BASE + ptr_cur;
      data_d       = pk_word;
      if (wrapped_cur) overrun_d = 1'b1;
      ptr_d        = (ptr_cur == LAST_PTR) ? '0 : ptr_cur + 1'b1;
      wrapped_d    = wrapped_cur || (ptr_cur == LAST_PTR);
    end
  end

  // Registered state; reset also kills any write scheduled for the next cycle.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      wrapped_q    <= 1'b0;
      overrun_q    <= 1'b0;
      wren_q       <= 1'b0;
      byteena_q    <= '0;
      frame_done_q <= 1'b0;
      address_q    <= BASE;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wrapped_q    <= wrapped_d;
      overrun_q    <= overrun_d;
      wren_q       <= wren_d;
      byteena_q    <= byteena_d;
      frame_done_q <= frame_done_d;
      address_q    <= address_d;
      data_q       <= data_d;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.wren_a    = wren_q;
  assign bus.byteena_a = byteena_q;
  assign bus.address_a = address_q;
  assign bus.data_a    = data_q;
  assign frame_done    = frame_done_q;
  assign overrun       = overrun_q;

`ifdef PIXEL_WRITER_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Completed frames only; the counter wraps naturally at 16 bits.
  always_comb begin
    frame_count_d = frame_done_d ? frame_count_q + 16'd1 : frame_count_q;
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (reset) frame_count_q <= '0;
    else       frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer (FRAME_WORDS=4 so the wrap is reachable).
module tb_pixel_writer;
  import pixel_pkg::*;

  localparam int ADDR_W      = 17;
  localparam int BASE_ADDR   = 0;
  localparam int FRAME_WORDS = 4;

  logic clk = 1'b0;
  logic reset;
  logic frame_done, overrun;
`ifdef PIXEL_WRITER_STATS_EN
  logic [15:0] frame_count;
`endif

  pixel_writer_if #(.ADDR_W(ADDR_W)) bus ();

  pixel_writer #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .FRAME_WORDS (FRAME_WORDS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .frame_done (frame_done),
    .overrun    (overrun)
`ifdef PIXEL_WRITER_STATS_EN
    ,
    .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v, s, e;
    logic [7:0]  d;
    logic        w;
    logic [16:0] a;
    logic [31:0] dat;
    logic [3:0]  be;
    logic        done;
    logic        ov;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic v, input logic s, input logic e,
                              input logic [7:0] d, input logic w, input logic [16:0] a,
                              input logic [31:0] dat, input logic [3:0] be,
                              input logic done, input logic ov);
    vec_t r;
    r.rst = rst; r.v = v; r.s = s; r.e = e; r.d = d;
    r.w = w; r.a = a; r.dat = dat; r.be = be; r.done = done; r.ov = ov;
    vecs.push_back(r);
  endfunction

  // Beat with no write expected.
  function automatic void beat(input logic s, input logic e, input logic [7:0] d, input logic ov);
    add(1'b0, 1'b1, s, e, d, 1'b0, '0, '0, 4'b0000, 1'b0, ov);
  endfunction

  // 20-pixel frame (values 1..20) spanning five words: wraps once.
  function automatic void add_wrap();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] p;
      p = 8'(i + 1);
      w = w | (32'(p) << (8 * (i % 4)));
      if (i % 4 == 3) begin
        add(1'b0, 1'b1, i == 0, i == 19, p, 1'b1, 17'((i / 4) % FRAME_WORDS), w,
            4'b1111, i == 19, i == 19);
        w = '0;
      end else begin
        beat(i == 0, 1'b0, p, 1'b0);
      end
    end
  endfunction

  task automatic drive(input logic rst, input logic v, input logic s, input logic e,
                       input logic [7:0] d);
    reset         = rst;
    bus.pix_valid = v;
    bus.pix_sof   = s;
    bus.pix_eof   = e;
    bus.pix_data  = d;
  endtask

  task automatic check_row(input string tag, input vec_t r);
    check({tag, " wren_a"},     32'(bus.wren_a),     32'(r.w));
    check({tag, " byteena_a"},  32'(bus.byteena_a),  32'(r.be));
    check({tag, " frame_done"}, 32'(frame_done),     32'(r.done));
    check({tag, " overrun"},    32'(overrun),        32'(r.ov));
    check({tag, " pix_ready"},  32'(bus.pix_ready),  32'(!r.rst));
    if (r.w || r.rst) begin
      check({tag, " address_a"}, 32'(bus.address_a), 32'(r.a));
      check({tag, " data_a"},    bus.data_a,         r.dat);
    end
`ifdef PIXEL_WRITER_STATS_EN
    check({tag, " frame_count"}, 32'(frame_count), 32'(exp_count));
`endif
  endtask

  initial begin
    int wr_seen;
    vec_t r;

    // Table: rst v s e d | w addr data be done ov
    // Four pixels, eof on the 4th: one full word.
    beat(1, 0, 8'h11, 0); beat(0, 0, 8'h22, 0); beat(0, 0, 8'h33, 0);
    add(0, 1, 0, 1, 8'h44, 1, 17'd0, 32'h44332211, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 17'd0, 32'h0, 4'b0000, 0, 0);
    // Six pixels: full word then a 2-byte final word.
    beat(1, 0, 8'h01, 0); beat(0, 0, 8'h02, 0); beat(0, 0, 8'h03, 0);
    add(0, 1, 0, 0, 8'h04, 1, 17'd0, 32'h04030201, 4'b1111, 0, 0);
    beat(0, 0, 8'h05, 0);
    add(0, 1, 0, 1, 8'h06, 1, 17'd1, 32'h00000605, 4'b0011, 1, 0);
    // Three pixels: eof at lane 2.
    beat(1, 0, 8'h07, 0); beat(0, 0, 8'h08, 0);
    add(0, 1, 0, 1, 8'h09, 1, 17'd0, 32'h00090807, 4'b0111, 1, 0);
    // Abort after two pixels, restart with four.
    beat(1, 0, 8'h01, 0); beat(0, 0, 8'h02, 0);
    beat(1, 0, 8'h0A, 0); beat(0, 0, 8'h0B, 0); beat(0, 0, 8'h0C, 0);
    add(0, 1, 0, 1, 8'h0D, 1, 17'd0, 32'h0D0C0B0A, 4'b1111, 1, 0);
    // Wrap: addresses 0,1,2,3,0 with overrun on the 5th write; sticky while idle.
    add_wrap();
    add(0, 0, 0, 0, 8'h00, 0, 17'd0, 32'h0, 4'b0000, 0, 1);
    // Next sof clears overrun.
    beat(1, 0, 8'h55, 0);
    add(0, 1, 0, 1, 8'h66, 1, 17'd0, 32'h00006655, 4'b0011, 1, 0);
    // Wrap again, then reset clears overrun.
    add_wrap();
    add(1, 0, 0, 0, 8'h00, 0, 17'd0, 32'h0, 4'b0000, 0, 0);
    // Reset on the lane-3 completing beat: no write follows.
    beat(1, 0, 8'hA1, 0); beat(0, 0, 8'hA2, 0); beat(0, 0, 8'hA3, 0);
    add(1, 1, 0, 0, 8'hA4, 0, 17'd0, 32'h0, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 17'd0, 32'h0, 4'b0000, 0, 0);

    // Initial reset.
    drive(1, 0, 0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    r = '{rst: 1, v: 0, s: 0, e: 0, d: 0, w: 0, a: 17'(BASE_ADDR), dat: 0, be: 0, done: 0, ov: 0};
    check_row("reset", r);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].d);
      @(posedge clk);
      #1;
      if (vecs[i].rst) exp_count = 0;
      else if (vecs[i].done) exp_count++;
      check_row($sformatf("row%0d", i), vecs[i]);
    end

    // Beats without sof in IDLE are dropped: no write for 20 cycles.
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, (i % 5) == 4, 8'(8'hC0 + i));
      @(posedge clk);
      #1;
      if (bus.wren_a) wr_seen++;
    end
    check("idle_drop writes", 32'(wr_seen), 32'd0);

    // One-pixel frame: sof and eof on the same beat.
    drive(0, 1, 1, 1, 8'hAB);
    @(posedge clk);
    #1;
    exp_count++;
    r = '{rst: 0, v: 1, s: 1, e: 1, d: 8'hAB, w: 1, a: 17'd0, dat: 32'h000000AB,
          be: 4'b0001, done: 1, ov: 0};
    check_row("single", r);

    drive(0, 0, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    check("single_after wren_a", 32'(bus.wren_a), 32'd0);
    check("single_after frame_done", 32'(frame_done), 32'd0);
    check("single_after data_hold", bus.data_a, 32'h000000AB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
